// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the ap_ctrl_hs handshake: issues a commanded burst of calls to an HLS core,
// timestamps each issue in a small FIFO and reports per-call latency, peak, counts and errors.
module ap_ctrl_hs_driver #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  input  logic             cmd_abort,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_value,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] issued,
  output logic [CNT_W-1:0] completed,
  output logic             burst_done,
  output logic [1:0]       err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERROR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] target;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0] ts_mem [DEPTH];
  logic [WD_W-1:0]  wdog;

  logic             fifo_empty, fifo_full;
  logic             push, pop, spurious, accept;
  logic             wd_count, wd_hit;
  logic [CNT_W-1:0] cur_lat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] max_of(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = ap_start && ap_ready;
  assign pop        = ap_done && !fifo_empty;
  assign spurious   = ap_done && fifo_empty;
  // Modular subtraction makes latency correct across timestamp wrap.
  assign cur_lat    = ts - ts_mem[rd_ptr[AW-1:0]];
  assign wd_count   = (state == RUN) && !fifo_empty && !ap_done;
  assign wd_hit     = wd_count && (wdog == WD_W'(TIMEOUT - 1));
  assign accept     = (state == IDLE) && cmd_valid && (cmd_count != '0) && !cmd_abort;

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    ap_start   = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_count != '0)) state_nxt = RUN;
      end
      RUN: begin
        // Full FIFO blocks issue even if a pop happens this cycle.
        ap_start = (issued < target) && !fifo_full;
        if (wd_hit)
          state_nxt = ERROR;
        else if ((issued == target) && (completed == target) && ap_idle)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        burst_done = 1'b1;
        state_nxt  = IDLE;
      end
      ERROR: state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
    if (cmd_abort) state_nxt = IDLE;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      ts        <= '0;
      target    <= '0;
      issued    <= '0;
      completed <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wdog      <= '0;
      lat_valid <= 1'b0;
      lat_value <= '0;
      lat_max   <= '0;
      err       <= '0;
    end else begin
      state     <= state_nxt;
      ts        <= ts + 1'b1;
      lat_valid <= pop && !cmd_abort;
      if (cmd_abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        wdog   <= '0;
        err    <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          issued <= sat_inc(issued);
        end
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          completed <= sat_inc(completed);
          lat_value <= cur_lat;
          lat_max   <= max_of(lat_max, cur_lat);
        end
        wdog <= wd_count ? wdog + 1'b1 : '0;
        if (wd_hit)   err[0] <= 1'b1;
        if (spurious) err[1] <= 1'b1;
        if (accept) begin
          target    <= cmd_count;
          issued    <= '0;
          completed <= '0;
          lat_max   <= '0;
        end
      end
    end
  end

  // Timestamp storage is pure data; pointers alone define validity.
  always_ff @(posedge ap_clk) begin
    if (push) ts_mem[wr_ptr[AW-1:0]] <= ts;
  end

endmodule
